// File: rtl/sram_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the SRAM pins and sram_arbiter.
// slave: arbiter side (CPU requests and ram_din in; fetch/data results and SRAM strobes out).
// master: environment side (the exact mirror of slave).
interface sram_arbiter_if #(
    parameter int RAM_AW = 18
);
    logic [15:0]       if_addr;
    logic [15:0]       if_inst;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_op;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_dout;
    logic [15:0]       ram_din;
    logic              ram_dq_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    modport slave (
        input  if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
        output if_inst, mem_rdata, mem_op, ram_addr, ram_dout,
        output ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
        input  if_inst, mem_rdata, mem_op, ram_addr, ram_dout,
        input  ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between instruction fetch and MEM-stage data access.
// Fetch runs every FETCH cycle; a MEM read/write preempts it with a
// SETUP / ACCESS(ACC_CYCLES) / RELEASE sequence and raises mem_op.
// Ports: clk, rst (async, active low), bus (sram_arbiter_if.slave):
//   if_addr/if_inst, mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata, mem_op,
//   ram_addr/ram_dout/ram_din/ram_dq_oe/ram_ce_n/ram_oe_n/ram_we_n.
// Optional: SRAM_STALL_STAT_EN adds output stall_cnt[15:0], counting
//   cycles with mem_op=1 (wraps).
module sram_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int RAM_AW     = 18
) (
    input logic          clk,
    input logic          rst,
    sram_arbiter_if.slave bus
`ifdef SRAM_STALL_STAT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    localparam int PAD = RAM_AW - 16;
    localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);
    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        FETCH,
        DSETUP,
        DACCESS,
        DRELEASE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        served;
    logic        dir_wr;
    logic [3:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        req;
    logic        last;

    // served hides the request still held in the cycle the pipeline
    // advances after an access, so it is not serviced twice.
    assign req  = (bus.mem_rd | bus.mem_wr) & ~served;
    assign last = (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (req) begin
                    state_nxt = DSETUP;
                end
            end
            DSETUP: begin
                state_nxt = DACCESS;
            end
            DACCESS: begin
                if (last) begin
                    state_nxt = DRELEASE;
                end
            end
            DRELEASE: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Strobes decode from the state register and latched direction only,
    // so an async reset drops we_n/dq_oe in the same instant.
    always_comb begin
        bus.ram_addr  = {{PAD{1'b0}}, addr_q};
        bus.ram_dout  = wdata_q;
        bus.ram_ce_n  = 1'b0;
        bus.ram_oe_n  = 1'b1;
        bus.ram_we_n  = 1'b1;
        bus.ram_dq_oe = 1'b0;
        bus.mem_op    = 1'b1;
        unique case (state)
            FETCH: begin
                bus.ram_addr = {{PAD{1'b0}}, bus.if_addr};
                bus.ram_oe_n = 1'b0;
                bus.mem_op   = req;
            end
            DSETUP: begin
                bus.ram_dq_oe = dir_wr;
            end
            DACCESS: begin
                if (dir_wr) begin
                    bus.ram_we_n  = 1'b0;
                    bus.ram_dq_oe = 1'b1;
                end else begin
                    bus.ram_oe_n = 1'b0;
                end
            end
            DRELEASE: begin
                // keep driving write data one more cycle for hold time
                bus.ram_dq_oe = dir_wr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served        <= 1'b0;
            dir_wr        <= 1'b0;
            cnt           <= 4'd0;
            addr_q        <= 16'h0000;
            wdata_q       <= 16'h0000;
            bus.if_inst   <= NOP;
            bus.mem_rdata <= 16'h0000;
        end else begin
            unique case (state)
                FETCH: begin
                    bus.if_inst <= bus.ram_din;
                    served      <= 1'b0;
                    if (req) begin
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        dir_wr  <= bus.mem_wr;
                    end
                end
                DSETUP: begin
                    cnt <= CNT_INIT;
                end
                DACCESS: begin
                    if (last) begin
                        if (!dir_wr) begin
                            bus.mem_rdata <= bus.ram_din;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DRELEASE: begin
                    served <= 1'b1;
                end
            endcase
        end
    end

`ifdef SRAM_STALL_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0000;
        end else if (bus.mem_op) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
